// File: rtl/gray_conv_sched.sv
// gray_conv_sched: round-robin scheduler time-sharing one gray-to-binary converter among N_REQ requesters.
// Define GRAY_CONV_SCHED_STATS_EN to add the 16-bit conv_count completed-conversion counter.
module gray_conv_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_gray,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_bin,
  output logic [ID_W-1:0]        rsp_id
`ifdef GRAY_CONV_SCHED_STATS_EN
  ,
  output logic [15:0]            conv_count
`endif
);
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
  state_t           r_state;
  logic [ID_W-1:0]  r_ptr, r_id, w_gid, w_idx;
  logic [WIDTH-1:0] r_gray, w_bin;
  logic             w_any, w_hs;
  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gid = w_idx;
      end
    end
  end
  assign req_ready = (rst_n && r_state == IDLE && w_any) ? N_REQ'(1) << w_gid : '0;
  assign w_hs      = |(req_valid & req_ready);
  // Each binary bit is the parity of the gray bits at and above it.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) w_bin[i] = ^(r_gray >> i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gray    <= '0;
      r_id      <= '0;
      rsp_valid <= 1'b0;
      rsp_bin   <= '0;
      rsp_id    <= '0;
`ifdef GRAY_CONV_SCHED_STATS_EN
      conv_count <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_gray  <= req_gray[int'(w_gid)*WIDTH +: WIDTH];
          r_id    <= w_gid;
          r_ptr   <= (w_gid == ID_W'(N_REQ - 1)) ? '0 : w_gid + 1'b1;
          r_state <= CONV;
        end
        CONV: begin
          rsp_bin   <= w_bin;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= HOLD;
        end
        HOLD: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          r_state   <= IDLE;
`ifdef GRAY_CONV_SCHED_STATS_EN
          conv_count <= conv_count + 16'd1;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gray_conv_sched.sv
// tb_gray_conv_sched: directed scoreboard bench for gray_conv_sched (N_REQ=4, WIDTH=4).
module tb_gray_conv_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_gray;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_bin;
  logic [1:0]  rsp_id;
`ifdef GRAY_CONV_SCHED_STATS_EN
  logic [15:0] conv_count;
`endif
  logic [3:0]  words [4];
  logic [5:0]  sb [$];
  int          checks = 0, failures = 0, cyc = 0, mptr = 0, mcnt = 0, last_acc = -1;

  assign req_gray = {words[3], words[2], words[1], words[0]};

  gray_conv_sched #(.N_REQ(4), .WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gray(req_gray),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_bin(rsp_bin), .rsp_id(rsp_id)
`ifdef GRAY_CONV_SCHED_STATS_EN
    , .conv_count(conv_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int exp_grant(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[(mptr + k) % 4]) return (mptr + k) % 4;
    return 0;
  endfunction

  task automatic check_count();
`ifdef GRAY_CONV_SCHED_STATS_EN
    chk("conv_count", conv_count, mcnt);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'hf;
    rsp_ready = 1'b0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_bin", rsp_bin, 0);
    chk("rst_id", rsp_id, 0);
    mptr = 0; mcnt = 0; last_acc = -1;
    sb.delete();
    check_count();
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // One full request/response; hold = backpressure cycles, gap = required accept spacing (-1 skips).
  task automatic txn(input logic [3:0] v, input int hold, input int gap);
    int g;
    logic [5:0] e;
    req_valid = v;
    rsp_ready = (hold == 0);
    #1;
    g = exp_grant(v);
    chk("grant", req_ready, 32'd1 << g);
    sb.push_back({2'(g), g2b(words[g])});
    tick();
    if (gap >= 0) chk("spacing", cyc - last_acc, gap);
    last_acc = cyc;
    mptr = (g + 1) % 4;
    chk("conv_ready", req_ready, 0);
    chk("conv_valid", rsp_valid, 0);
    tick();
    e = sb.pop_front();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_bin", rsp_bin, e[3:0]);
    chk("rsp_id", rsp_id, e[5:4]);
    for (int c = 0; c < hold; c++) begin
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_bin", rsp_bin, e[3:0]);
      chk("hold_id", rsp_id, e[5:4]);
      chk("hold_ready", req_ready, 0);
      check_count();
    end
    rsp_ready = 1'b1;
    tick();
    mcnt++;
    chk("done_valid", rsp_valid, 0);
    check_count();
  endtask

  initial begin
    words[0] = 4'b0000; words[1] = 4'b0000; words[2] = 4'b1011; words[3] = 4'b0000;
    do_reset();
    txn(4'b0100, 0, -1);
    chk("single_id", rsp_id, 2);
    chk("single_bin_model", g2b(words[2]), 4'b1101);

    do_reset();
    words[0] = 4'b0000; words[1] = 4'b0110; words[2] = 4'b1111; words[3] = 4'b1000;
    txn(4'hf, 0, -1);
    for (int n = 0; n < 3; n++) txn(4'hf, 0, 3);
    for (int n = 0; n < 8; n++) txn(4'b1010, 0, 3);

    txn(4'b0001, 10, -1);

    do_reset();
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 4; i++) words[i] = 4'($urandom_range(0, 15));
      txn(4'($urandom_range(1, 15)), 0, -1);
    end
    check_count();
    txn(4'b0100, 6, -1);

    words[1] = 4'b1001;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("mid_grant", req_ready, 32'd1 << exp_grant(4'b0010));
    tick();
    tick();
    chk("mid_hold_valid", rsp_valid, 1);
    req_valid = 4'hf;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    mptr = 0; mcnt = 0; last_acc = -1;
    check_count();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);
    txn(4'hf, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
